// File: rtl/cmd_arbiter.sv
// Two-requester arbiter (UART host / tour sequencer) in front of cmd_proc.
// Define CMD_ARB_RR_EN for round-robin tie-breaking instead of PRIO_TOUR.
module cmd_arbiter #(
  parameter bit PRIO_TOUR = 1'b1,
  parameter int TO_W      = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] uart_cmd,
  input  logic        uart_cmd_rdy,
  output logic        uart_clr_cmd_rdy,
  output logic        uart_trmt,
  input  logic [15:0] tour_cmd,
  input  logic        tour_cmd_rdy,
  output logic        tour_clr_cmd_rdy,
  output logic        tour_resp_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        owner,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST =
    {TO_W{1'b1}} - 1'b1;

  state_t          state;
  logic [15:0]     cmd_reg;
  logic [TO_W-1:0] cnt;
  logic            req;
  logic            grant_tour;

  assign req  = uart_cmd_rdy | tour_cmd_rdy;
  assign cmd  = cmd_reg;
  assign busy = (state != IDLE);

`ifdef CMD_ARB_RR_EN
  logic last_tour;

  assign grant_tour = tour_cmd_rdy &
    (~uart_cmd_rdy | ~last_tour);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_tour <= 1'b0;
    else if (state == IDLE && req)
      last_tour <= grant_tour;
  end
`else
  assign grant_tour = tour_cmd_rdy &
    (~uart_cmd_rdy | PRIO_TOUR);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cmd_reg          <= '0;
      cmd_rdy          <= 1'b0;
      owner            <= 1'b0;
      cnt              <= '0;
      uart_clr_cmd_rdy <= 1'b0;
      tour_clr_cmd_rdy <= 1'b0;
      uart_trmt        <= 1'b0;
      tour_resp_rdy    <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      uart_clr_cmd_rdy <= 1'b0;
      tour_clr_cmd_rdy <= 1'b0;
      uart_trmt        <= 1'b0;
      tour_resp_rdy    <= 1'b0;
      timeout_err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            cmd_reg          <= grant_tour ? tour_cmd
                                           : uart_cmd;
            owner            <= grant_tour;
            cmd_rdy          <= 1'b1;
            tour_clr_cmd_rdy <= grant_tour;
            uart_clr_cmd_rdy <= ~grant_tour;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
            cnt     <= '0;
            if (send_resp) begin
              uart_trmt     <= ~owner;
              tour_resp_rdy <= owner;
              state         <= IDLE;
            end else begin
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          cnt <= cnt + 1'b1;
          // A response in the final cycle beats the timeout.
          if (send_resp) begin
            uart_trmt     <= ~owner;
            tour_resp_rdy <= owner;
            state         <= IDLE;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: spec-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_cmd_arbiter;

  localparam bit PRIO   = 1'b1;
  localparam int TOW    = 4;
  localparam int WAITS  = (1 << TOW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] uart_cmd, tour_cmd, cmd;
  logic        uart_cmd_rdy, tour_cmd_rdy;
  logic        uart_clr_cmd_rdy, uart_trmt;
  logic        tour_clr_cmd_rdy, tour_resp_rdy;
  logic        cmd_rdy, clr_cmd_rdy, send_resp;
  logic        owner, busy, timeout_err;

  int total = 0;
  int bad   = 0;

  cmd_arbiter #(.PRIO_TOUR(PRIO), .TO_W(TOW)) dut (
    .clk(clk), .rst(rst),
    .uart_cmd(uart_cmd), .uart_cmd_rdy(uart_cmd_rdy),
    .uart_clr_cmd_rdy(uart_clr_cmd_rdy),
    .uart_trmt(uart_trmt),
    .tour_cmd(tour_cmd), .tour_cmd_rdy(tour_cmd_rdy),
    .tour_clr_cmd_rdy(tour_clr_cmd_rdy),
    .tour_resp_rdy(tour_resp_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .owner(owner), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Model: is a command outstanding, has cmd_proc taken it,
  // how many wait cycles have elapsed, who won last.
  bit          m_act, m_taken, m_last;
  int          m_waited;
  logic [15:0] e_cmd;
  logic        e_rdy, e_own, e_uclr, e_tclr;
  logic        e_utr, e_trr, e_to;

  function automatic logic pick(logic u, logic t,
                                logic last);
    if (!u) return 1'b1;
    if (!t) return 1'b0;
`ifdef CMD_ARB_RR_EN
    return ~last;
`else
    return PRIO;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 0; m_taken <= 0; m_last <= 0;
      m_waited <= 0;
      e_cmd <= '0; e_rdy <= 0; e_own <= 0;
      e_uclr <= 0; e_tclr <= 0;
      e_utr <= 0; e_trr <= 0; e_to <= 0;
    end else begin
      e_uclr <= 0; e_tclr <= 0;
      e_utr <= 0; e_trr <= 0; e_to <= 0;
      if (!m_act) begin
        if (uart_cmd_rdy || tour_cmd_rdy) begin
          logic w;
          w = pick(uart_cmd_rdy, tour_cmd_rdy, m_last);
          m_act <= 1; m_taken <= 0; m_last <= w;
          e_own <= w;
          e_cmd <= w ? tour_cmd : uart_cmd;
          e_rdy <= 1;
          e_tclr <= w; e_uclr <= !w;
        end
      end else if (!m_taken) begin
        if (clr_cmd_rdy) begin
          e_rdy <= 0;
          if (send_resp) begin
            m_act <= 0;
            e_utr <= !e_own; e_trr <= e_own;
          end else begin
            m_taken <= 1; m_waited <= 0;
          end
        end
      end else begin
        if (send_resp) begin
          m_act <= 0;
          e_utr <= !e_own; e_trr <= e_own;
        end else if (m_waited == WAITS - 1) begin
          m_act <= 0; e_to <= 1;
        end else begin
          m_waited <= m_waited + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [24:0] act, exp;
    act = {cmd, cmd_rdy, owner, busy, uart_clr_cmd_rdy,
           tour_clr_cmd_rdy, uart_trmt, tour_resp_rdy,
           timeout_err};
    exp = {e_cmd, e_rdy, e_own, m_act, e_uclr, e_tclr,
           e_utr, e_trr, e_to};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cycle@%0t: got %h expected %h",
               $time, act, exp);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic serve(input logic [15:0] xcmd,
                       input logic xown,
                       input bit drop,
                       input bit together);
    int n;
    n = 0;
    while (!cmd_rdy && n < 10) begin
      cyc(1);
      n++;
    end
    chk("grant_seen", cmd_rdy, 1);
    chk("grant_cmd", cmd, xcmd);
    chk("grant_owner", owner, xown);
    chk("grant_clr",
        xown ? tour_clr_cmd_rdy : uart_clr_cmd_rdy, 1);
    if (drop) begin
      if (xown) tour_cmd_rdy = 0;
      else uart_cmd_rdy = 0;
    end
    cyc(1);
    chk("clr_one_shot",
        uart_clr_cmd_rdy | tour_clr_cmd_rdy, 0);
    chk("rdy_held", cmd_rdy, 1);
    clr_cmd_rdy = 1;
    send_resp   = together;
    cyc(1);
    clr_cmd_rdy = 0;
    send_resp   = 0;
    if (!together) begin
      chk("rdy_fell", cmd_rdy, 0);
      chk("wait_busy", busy, 1);
      cyc(2);
      send_resp = 1;
      cyc(1);
      send_resp = 0;
    end
    chk("resp_uart", uart_trmt, !xown);
    chk("resp_tour", tour_resp_rdy, xown);
  endtask

  initial begin
    int n;
    logic [2:0] order;
    rst = 1;
    uart_cmd = '0; tour_cmd = '0;
    uart_cmd_rdy = 0; tour_cmd_rdy = 0;
    clr_cmd_rdy = 0; send_resp = 0;
    cyc(2);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rdy", cmd_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    rst = 0;
    cyc(1);

    uart_cmd = 16'h2000; uart_cmd_rdy = 1;
    serve(16'h2000, 0, 1, 0);
    cyc(1);
    chk("trmt_one_cycle", uart_trmt, 0);

    uart_cmd = 16'h4001; tour_cmd = 16'h4002;
    uart_cmd_rdy = 1; tour_cmd_rdy = 1;
    serve(16'h4002, 1, 1, 0);
    serve(16'h4001, 0, 1, 0);
    cyc(2);

    uart_cmd = 16'h0a0a; uart_cmd_rdy = 1;
    serve(16'h0a0a, 0, 1, 1);
    cyc(2);

    rst = 1; cyc(1); rst = 0; cyc(1);
`ifdef CMD_ARB_RR_EN
    order = 3'b101;
`else
    order = 3'b111;
`endif
    uart_cmd_rdy = 1; tour_cmd_rdy = 1;
    for (int r = 0; r < 3; r++) begin
      serve(order[2-r] ? 16'h4002 : 16'h4001,
            order[2-r], 0, 0);
      if (r == 2) begin
        uart_cmd_rdy = 0; tour_cmd_rdy = 0;
      end
    end
    cyc(2);

    uart_cmd = 16'h1234; uart_cmd_rdy = 1;
    cyc(1);
    uart_cmd_rdy = 0;
    clr_cmd_rdy = 1;
    cyc(1);
    clr_cmd_rdy = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (timeout_err) break;
      if (busy && !cmd_rdy) n++;
      cyc(1);
    end
    chk("to_pulse", timeout_err, 1);
    chk("to_wait_cycles", n, WAITS);
    chk("to_no_trmt", uart_trmt | tour_resp_rdy, 0);
    chk("to_idle", busy, 0);
    tour_cmd = 16'h5555; tour_cmd_rdy = 1;
    serve(16'h5555, 1, 1, 0);
    cyc(2);

    uart_cmd = 16'h0abc; uart_cmd_rdy = 1;
    cyc(1);
    uart_cmd_rdy = 0;
    clr_cmd_rdy = 1;
    cyc(1);
    clr_cmd_rdy = 0;
    cyc(WAITS - 1);
    send_resp = 1;
    cyc(1);
    send_resp = 0;
    chk("late_resp_trmt", uart_trmt, 1);
    chk("late_resp_no_to", timeout_err, 0);
    cyc(2);

    uart_cmd = 16'h7777; uart_cmd_rdy = 1;
    cyc(1);
    uart_cmd_rdy = 0;
    clr_cmd_rdy = 1;
    cyc(1);
    clr_cmd_rdy = 0;
    cyc(2);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rdy", cmd_rdy, 0);
    chk("arst_cmd", cmd, 16'h0000);
    rst = 0;
    cyc(1);
    send_resp = 1;
    cyc(1);
    send_resp = 0;
    chk("arst_no_trmt", uart_trmt | tour_resp_rdy, 0);

    send_resp = 1; clr_cmd_rdy = 1;
    cyc(2);
    chk("stray_busy", busy, 0);
    chk("stray_pulses",
        {uart_trmt, tour_resp_rdy, timeout_err,
         uart_clr_cmd_rdy, tour_clr_cmd_rdy}, 0);
    send_resp = 0; clr_cmd_rdy = 0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
